// File: rtl/vrbridge_decode.sv
// Avalon-ST Video (VIP) to raw-stream decoder: control packets load frame geometry, video packets pass through minus header.
// Optional DECODE_CHECK_EN adds a per-frame beat count check against im_width*im_height, reported on size_err.
module vrbridge_decode #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          DATA_BITS      = 8,
  parameter int          DATA_PLANES    = 1,
  parameter logic [15:0] VIP_WIDTH      = 16'd720,
  parameter logic [15:0] VIP_HEIGHT     = 16'd576,
  parameter logic [3:0]  VIP_INTERLACED = 4'b0010
) (
  input  logic                  vst_clk,
  input  logic                  vst_rst_n,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  output logic                  raw_startofpacket,
  output logic                  raw_endofpacket,
  input  logic                  raw_ready,
  output logic [15:0]           im_width,
  output logic [15:0]           im_height,
  output logic [3:0]            im_interlaced,
  output logic                  im_update
`ifdef DECODE_CHECK_EN
  ,
  output logic                  size_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CTRL  = 2'd1,
    ST_DROP  = 2'd2,
    ST_VIDEO = 2'd3
  } state_t;

  state_t      state_q;
  logic        first_q;
  logic [3:0]  nib_cnt_q;
  logic [3:0]  shadow_q [9];
  logic [3:0]  shadow_d [9];
  logic [15:0] im_width_q;
  logic [15:0] im_height_q;
  logic [3:0]  im_interlaced_q;
  logic        im_update_q;

  logic        xfer;
  logic        hdr;
  logic        dat;
  logic        ctrl_dat;
  logic        vid_dat;
  logic [3:0]  ptype;
  logic [4:0]  nib_sum;
  logic [3:0]  nib_next;
  logic [3:0]  slot;

  assign din_ready = (state_q == ST_VIDEO) ? raw_ready : 1'b1;
  assign xfer      = din_valid & din_ready;
  assign hdr       = xfer & din_startofpacket;
  assign dat       = xfer & ~din_startofpacket;
  assign ctrl_dat  = dat & (state_q == ST_CTRL);
  assign vid_dat   = dat & (state_q == ST_VIDEO);
  assign ptype     = din_data[3:0];

  assign raw_data          = din_data;
  assign raw_valid         = (state_q == ST_VIDEO) & din_valid & ~din_startofpacket;
  assign raw_startofpacket = raw_valid & first_q;
  assign raw_endofpacket   = din_endofpacket;

  assign im_width      = im_width_q;
  assign im_height     = im_height_q;
  assign im_interlaced = im_interlaced_q;
  assign im_update     = im_update_q;

  // Each control beat carries DATA_PLANES nibbles; the count saturates once all 9 are seen.
  assign nib_sum  = {1'b0, nib_cnt_q} + 5'(DATA_PLANES);
  assign nib_next = (nib_sum >= 5'd9) ? 4'd9 : nib_sum[3:0];

  always_comb begin
    slot = 4'd0;
    for (int k = 0; k < 9; k++) begin
      shadow_d[k] = shadow_q[k];
    end
    if (ctrl_dat) begin
      for (int p = 0; p < DATA_PLANES; p++) begin
        slot = nib_cnt_q + 4'(p);
        if (slot < 4'd9) begin
          shadow_d[slot] = din_data[p*DATA_BITS +: 4];
        end
      end
    end
  end

  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      state_q         <= ST_IDLE;
      first_q         <= 1'b0;
      nib_cnt_q       <= 4'd0;
      im_width_q      <= VIP_WIDTH;
      im_height_q     <= VIP_HEIGHT;
      im_interlaced_q <= VIP_INTERLACED;
      im_update_q     <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= 4'd0;
      end
    end else begin
      im_update_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
      if (ctrl_dat) begin
        nib_cnt_q <= nib_next;
      end

      if (hdr) begin
        // A header is honoured in every state; in VIDEO it truncates the current frame.
        first_q <= (ptype == 4'h0);
        if (ptype == 4'hF) begin
          nib_cnt_q <= 4'd0;
        end
        if (din_endofpacket) begin
          state_q <= ST_IDLE;
        end else if (ptype == 4'h0) begin
          state_q <= ST_VIDEO;
        end else if (ptype == 4'hF) begin
          state_q <= ST_CTRL;
        end else begin
          state_q <= ST_DROP;
        end
      end else if (dat) begin
        case (state_q)
          ST_CTRL: begin
            if (din_endofpacket) begin
              state_q <= ST_IDLE;
              if (nib_next == 4'd9) begin
                im_width_q      <= {shadow_d[0], shadow_d[1], shadow_d[2], shadow_d[3]};
                im_height_q     <= {shadow_d[4], shadow_d[5], shadow_d[6], shadow_d[7]};
                im_interlaced_q <= shadow_d[8];
                im_update_q     <= 1'b1;
              end
            end
          end
          ST_DROP: begin
            if (din_endofpacket) begin
              state_q <= ST_IDLE;
            end
          end
          ST_VIDEO: begin
            first_q <= 1'b0;
            if (din_endofpacket) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef DECODE_CHECK_EN
  logic [31:0] beat_cnt_q;
  logic        size_err_q;
  logic [31:0] frame_px;

  assign frame_px = 32'(im_width_q) * 32'(im_height_q);
  assign size_err = size_err_q;

  always_ff @(posedge vst_clk or negedge vst_rst_n) begin
    if (!vst_rst_n) begin
      beat_cnt_q <= 32'd0;
      size_err_q <= 1'b0;
    end else begin
      size_err_q <= 1'b0;
      if (hdr) begin
        if (state_q == ST_VIDEO) begin
          size_err_q <= 1'b1;
        end
        if (ptype == 4'h0) begin
          beat_cnt_q <= 32'd0;
        end
      end else if (vid_dat) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
        if (din_endofpacket && ((beat_cnt_q + 32'd1) != frame_px)) begin
          size_err_q <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/vrbridge_decode.md
# vrbridge_decode

Avalon-ST Video (VIP) to raw-stream decoder: the receive-side counterpart of the bridge encoder. Consumes VIP packets on `vst_clk`, parses control packets into registered frame geometry, strips the header beat from video packets and forwards pixels as a plain sop/eop/valid/ready stream. It sits between a VIP pipeline output and raw sinks such as a frame-sync generator or a dual-clock pixel FIFO.

## Interface
- `DATA_WIDTH`, 8: beat width; equals `DATA_BITS*DATA_PLANES`.
- `DATA_BITS`, 8: bits per symbol (colour plane); must be at least 4.
- `DATA_PLANES`, 1: symbols per beat, in parallel; legal range 1..4.
- `VIP_WIDTH`, 16'd720: reset value of `im_width`.
- `VIP_HEIGHT`, 16'd576: reset value of `im_height`.
- `VIP_INTERLACED`, 4'b0010: reset value of `im_interlaced`.
- `vst_clk`  in  1  single clock; all logic on the rising edge.
- `vst_rst_n`  in  1  asynchronous, active-low reset.
- `din_data`  in  DATA_WIDTH  VIP beat data.
- `din_valid`, `din_startofpacket`, `din_endofpacket`  in  1  VIP qualifiers.
- `din_ready`  out  1  VIP backpressure.
- `raw_data`  out  DATA_WIDTH  pixel data.
- `raw_valid`, `raw_startofpacket`, `raw_endofpacket`  out  1  raw qualifiers.
- `raw_ready`  in  1  raw sink backpressure.
- `im_width`, `im_height`  out  16  last accepted control-packet geometry.
- `im_interlaced`  out  4  last accepted interlace nibble.
- `im_update`  out  1  one-cycle pulse when the geometry registers load.
- `size_err`  out  1  one-cycle pulse; present only with `DECODE_CHECK_EN`.

## Operation
- A beat transfers when `din_valid & din_ready`. A transferred beat with `din_startofpacket=1` is always a header. Packet type is `din_data[3:0]` (symbol 0, low nibble).
- States:
  - IDLE: `din_ready=1`.
  - CTRL: `din_ready=1`.
  - DROP: `din_ready=1`.
  - VIDEO: `din_ready=raw_ready`.
- Header handling, from any state:
  - Type 0x0 goes to VIDEO.
  - Type 0xF goes to CTRL and clears the nibble counter.
  - Any other type goes to DROP.
  - If the header also has eop, the block returns to IDLE and nothing is output.
- Header in VIDEO: an abort. The truncated raw frame is left without an eop.
- Non-sop beat in IDLE: discarded.
- CTRL nibble mapping:
  - Nibble k comes from beat k/DATA_PLANES, symbol k%DATA_PLANES, bits [3:0] of that symbol.
  - Nibbles 0..3 are width [15:12], [11:8], [7:4], [3:0].
  - Nibbles 4..7 are height in the same order.
  - Nibble 8 is interlaced.
  - The 4-bit nibble counter saturates at 9; nibbles beyond 9 are ignored.
- CTRL at eop: if all 9 nibbles were received, shadow values copy to the `im_*` outputs and `im_update` pulses. Otherwise the outputs are left unchanged. Either way the state goes to IDLE.
- VIDEO data path is combinational pass-through:
  - `raw_data=din_data`
  - `raw_valid=din_valid & ~din_startofpacket` while in VIDEO
  - `raw_endofpacket=din_endofpacket`
  - `raw_startofpacket` is high on the first data beat after the header, tracked by a `first` flag that clears on that beat's transfer.
- VIDEO eop transfer returns to IDLE. DROP consumes beats until eop, then returns to IDLE.

## Timing
- Reset values:
  - state IDLE, so `raw_valid=0`, `raw_startofpacket=0` and `din_ready=1`.
  - `im_*` outputs hold the parameter values.
  - `im_update=0`, `size_err=0`.
- Latency:
  - Data path: 0 cycles; `din_ready` depends combinationally on `raw_ready` in VIDEO.
  - Geometry: `im_*` updates one cycle after the control-packet eop transfer, and `im_update` is high in that same cycle.
- Back-to-back: a header may transfer in the cycle after an eop, with no bubble required.
- Held data: while `raw_valid & ~raw_ready`, `din_ready=0`, so `din_data` is held by the source.

## Configuration
- Macro: `DECODE_CHECK_EN`.
- Defined:
  - A 32-bit beat counter counts transferred VIDEO data beats. It clears on each type-0x0 header.
  - At the VIDEO eop transfer, the count is compared with `im_width*im_height` (32-bit product).
  - A mismatch pulses `size_err` one cycle later.
  - A header arriving in VIDEO (abort) also pulses `size_err`.
- Undefined: the counter, comparator and `size_err` port are absent.

## Test plan
- Control packet with width 640 (0x0280), height 480 (0x01E0), interlaced 0x3, `DATA_PLANES=1`: 1 header + 9 beats -> `im_update` pulse; `im_width=640`, `im_height=480`, `im_interlaced=3`.
- Same geometry with `DATA_PLANES=3`: header + 3 beats -> identical outputs. A short control packet with 6 nibbles -> outputs unchanged, no `im_update`.
- Video packet, header + 4 beats 0x11..0x44, `raw_ready` toggled 1/0 -> exactly 4 raw beats in order, sop on 0x11, eop on 0x44, no data lost or duplicated.
- Packet type 0x5 with 3 beats, then a type-0x0 packet -> no raw output for the first packet; the second is forwarded normally.
- Video header arriving mid-frame, then reset asserted mid-frame -> the new header is consumed and the raw stream restarts with sop. On reset, outputs go to reset values immediately and `im_width=720`.
- `DECODE_CHECK_EN` with a 4x2 geometry: 8 beats -> no `size_err`; 7 beats -> `size_err` pulses one cycle after eop.
